// File: rtl/fft16_ctrl.sv
// fft16_ctrl -- control sequencer for a 16-point radix-4 FFT built around an
// external 4-input butterfly.
//
// A frame is four groups of four complex samples. Each sample is 17b Re plus
// 17b Im, in two's complement. The controller works in four steps:
//   1. It collects the four groups into a local buffer (LOAD).
//   2. It pushes each group through the butterfly with rotation codes
//      000..011 (S1). Results are written back in place (S1W drains).
//   3. It does a second pass with codes 100..111 (S2, S2W).
//   4. It streams the four result groups out (UNLOAD).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input group handshake, in_data[135:0]
//   bf_in, bf_rot         operand group and rotation code to the butterfly
//   bf_out                butterfly result, valid BF_LAT cycles after issue
//   out_valid/out_ready   result group handshake, out_data[135:0], out_idx k
//                         (group k holds bins k, k+4, k+8, k+12)
//   busy                  high whenever the controller is not in LOAD
//   frame_done            one-cycle pulse on the final output handshake
//
// Parameter: BF_LAT (1..4) is the butterfly pipeline latency in cycles.
//
// Optional feature: define FFT16_CTRL_SCALE_EN to make stage-2 captures
// store each 17b component arithmetically shifted right by 2. Stage-1
// captures are never scaled.
module fft16_ctrl #(
  parameter int unsigned BF_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [135:0] in_data,
  output logic [135:0] bf_in,
  output logic [2:0]   bf_rot,
  input  logic [135:0] bf_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [135:0] out_data,
  output logic [1:0]   out_idx,
  output logic         busy,
  output logic         frame_done
);

  typedef enum logic [2:0] {LOAD, S1, S1W, S2, S2W, UNLOAD} state_t;

  // The drain states reuse cnt as a wait counter; BF_LAT <= 4 fits in 2 bits.
  localparam logic [1:0] LAST_WAIT = 2'(BF_LAT - 1);

  state_t       state, state_nx;
  logic [1:0]   cnt, cnt_nx;
  logic         issue;
  logic [135:0] grp_buf [4];

  // Tag pipe: the slot each in-flight operation writes back to.
  logic [BF_LAT-1:0] tag_v;
  logic [1:0]        tag_slot [BF_LAT];
  logic [135:0]      cap_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    issue      = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_idx    = '0;
    bf_in      = '0;
    bf_rot     = '0;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state)
      LOAD: begin
        busy     = 1'b0;
        in_ready = 1'b1;
        if (in_valid) begin
          cnt_nx = cnt + 2'd1;
          if (cnt == 2'd3) state_nx = S1;
        end
      end
      S1: begin
        issue  = 1'b1;
        bf_in  = grp_buf[cnt];
        bf_rot = {1'b0, cnt};
        cnt_nx = cnt + 2'd1;
        if (cnt == 2'd3) state_nx = S1W;
      end
      S1W: begin
        if (cnt == LAST_WAIT) begin
          cnt_nx   = '0;
          state_nx = S2;
        end else begin
          cnt_nx = cnt + 2'd1;
        end
      end
      S2: begin
        issue  = 1'b1;
        bf_in  = grp_buf[cnt];
        bf_rot = {1'b1, cnt};
        cnt_nx = cnt + 2'd1;
        if (cnt == 2'd3) state_nx = S2W;
      end
      S2W: begin
        if (cnt == LAST_WAIT) begin
          cnt_nx   = '0;
          state_nx = UNLOAD;
        end else begin
          cnt_nx = cnt + 2'd1;
        end
      end
      UNLOAD: begin
        out_valid = 1'b1;
        out_data  = grp_buf[cnt];
        out_idx   = cnt;
        if (out_ready) begin
          cnt_nx = cnt + 2'd1;
          if (cnt == 2'd3) begin
            state_nx   = LOAD;
            frame_done = 1'b1;
          end
        end
      end
      default: begin
        state_nx = LOAD;
        cnt_nx   = '0;
      end
    endcase
  end

  // Reset clears the tags, so results still in the butterfly are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      for (int unsigned i = 0; i < BF_LAT; i++) tag_slot[i] <= '0;
    end else begin
      tag_v[0]    <= issue;
      tag_slot[0] <= cnt;
      for (int unsigned i = 1; i < BF_LAT; i++) begin
        tag_v[i]    <= tag_v[i-1];
        tag_slot[i] <= tag_slot[i-1];
      end
    end
  end

`ifdef FFT16_CTRL_SCALE_EN
  // Every stage-2 result lands while the FSM is in S2 or S2W. Every stage-1
  // result has landed before S2 begins, so the state selects the scaling.
  logic stage2;
  assign stage2 = (state == S2) || (state == S2W);

  always_comb begin
    cap_data = bf_out;
    if (stage2) begin
      for (int unsigned i = 0; i < 8; i++)
        cap_data[i*17 +: 17] = {{2{bf_out[i*17+16]}}, bf_out[i*17+2 +: 15]};
    end
  end
`else
  assign cap_data = bf_out;
`endif

  // Loads and captures never coincide: captures only occur between S1 and
  // S2W, and loads only occur in LOAD. The buffer is deliberately not reset.
  always_ff @(posedge clk) begin
    if (in_ready && in_valid)
      grp_buf[cnt] <= in_data;
    else if (tag_v[BF_LAT-1])
      grp_buf[tag_slot[BF_LAT-1]] <= cap_data;
  end

endmodule

// File: tb/tb_fft16_ctrl.sv
module tb_fft16_ctrl;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [135:0] in_data;
  logic         out_ready;

  logic         in_ready1, out_valid1, busy1, frame_done1;
  logic [135:0] bf_in1, bf_out1, out_data1;
  logic [2:0]   bf_rot1;
  logic [1:0]   out_idx1;

  logic         in_ready3, out_valid3, busy3, frame_done3;
  logic [135:0] bf_in3, bf_out3, out_data3;
  logic [2:0]   bf_rot3;
  logic [1:0]   out_idx3;

  int checks;
  int errors;

  logic [135:0] grp [4];
  logic [135:0] dly1 [4];
  logic [135:0] dly3 [4];

  fft16_ctrl #(.BF_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .bf_in(bf_in1), .bf_rot(bf_rot1), .bf_out(bf_out1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_idx(out_idx1), .busy(busy1), .frame_done(frame_done1)
  );

  fft16_ctrl #(.BF_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
    .in_data(in_data), .bf_in(bf_in3), .bf_rot(bf_rot3), .bf_out(bf_out3),
    .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
    .out_idx(out_idx3), .busy(busy3), .frame_done(frame_done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Identity butterfly stubs with latency 1 and 3.
  always @(posedge clk) begin
    dly1[0] <= bf_in1;
    dly3[0] <= bf_in3;
    for (int i = 1; i < 4; i++) begin
      dly1[i] <= dly1[i-1];
      dly3[i] <= dly3[i-1];
    end
  end
  assign bf_out1 = dly1[0];
  assign bf_out3 = dly3[2];

  task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [135:0] exp_out(input logic [135:0] g);
    logic [135:0] r;
    r = g;
`ifdef FFT16_CTRL_SCALE_EN
    for (int i = 0; i < 8; i++) begin
      logic signed [16:0] f;
      f = g[i*17 +: 17];
      r[i*17 +: 17] = f >>> 2;
    end
`endif
    return r;
  endfunction

  function automatic logic [135:0] mk(input int j);
    return {17'(j + 17'h100), 102'h0, 17'(3 * j + 5)};
  endfunction

  // Expected {in_ready,busy,out_valid,frame_done,out_idx,bf_rot}, bf_in and
  // out_data in cycle t after the 4th load (cycle 0), with out_ready high.
  task automatic exp_cycle(input int lat, input int t, output logic [8:0] ctrl,
                           output logic [135:0] bfi, output logic [135:0] od);
    int s2;
    int u;
    logic ir, bz, ov, fd;
    logic [1:0] idx;
    logic [2:0] rot;
    s2 = 5 + lat;
    u  = 9 + 2 * lat;
    ir = 1'b0; bz = 1'b1; ov = 1'b0; fd = 1'b0; idx = '0; rot = '0;
    bfi = '0;
    od  = '0;
    if (t >= 1 && t <= 4) begin
      rot = {1'b0, 2'(t - 1)};
      bfi = grp[t-1];
    end else if (t >= s2 && t <= s2 + 3) begin
      rot = {1'b1, 2'(t - s2)};
      bfi = grp[t-s2];
    end else if (t >= u && t <= u + 3) begin
      ov  = 1'b1;
      idx = 2'(t - u);
      od  = exp_out(grp[t-u]);
      fd  = (t == u + 3);
    end else if (t > u + 3) begin
      bz = 1'b0;
      ir = 1'b1;
    end
    ctrl = {ir, bz, ov, fd, idx, rot};
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ctrl1"}, 136'({in_ready1, busy1, out_valid1, frame_done1, out_idx1, bf_rot1}), 136'h100);
    check({tag, "_bfin1"}, bf_in1, '0);
    check({tag, "_odat1"}, out_data1, '0);
    check({tag, "_ctrl3"}, 136'({in_ready3, busy3, out_valid3, frame_done3, out_idx3, bf_rot3}), 136'h100);
    check({tag, "_bfin3"}, bf_in3, '0);
    check({tag, "_odat3"}, out_data3, '0);
  endtask

  // Loads grp back-to-back into both controllers, then checks every cycle
  // of the frame against the timing model.
  task automatic run_frame(input string tag);
    logic [8:0]   ec;
    logic [135:0] eb, eo;
    for (int g = 0; g < 4; g++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = grp[g];
      out_ready = 1'b1;
      #1;
      check({tag, "_ld_ready"}, 136'({in_ready1, busy1, in_ready3, busy3}), 136'b1010);
    end
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = '0;
      #1;
      exp_cycle(1, t, ec, eb, eo);
      check($sformatf("%s_l1_ctrl_t%0d", tag, t), 136'({in_ready1, busy1, out_valid1, frame_done1, out_idx1, bf_rot1}), 136'(ec));
      check($sformatf("%s_l1_bfin_t%0d", tag, t), bf_in1, eb);
      check($sformatf("%s_l1_odat_t%0d", tag, t), out_data1, eo);
      exp_cycle(3, t, ec, eb, eo);
      check($sformatf("%s_l3_ctrl_t%0d", tag, t), 136'({in_ready3, busy3, out_valid3, frame_done3, out_idx3, bf_rot3}), 136'(ec));
      check($sformatf("%s_l3_bfin_t%0d", tag, t), bf_in3, eb);
      check($sformatf("%s_l3_odat_t%0d", tag, t), out_data3, eo);
    end
  endtask

  initial begin
    int acc_n, hs_n, hold, done_j, busy_ready;
    bit held_once;
    checks = 0;
    errors = 0;
    grp[0] = 136'h1;
    grp[1] = 136'h2;
    grp[2] = 136'h3;
    grp[3] = {102'h0, 17'h1FFFC, 17'h00007};
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

    #3;
    check_reset("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_frame("f1");

    // in_valid held high all frame, output stall of 5 cycles at idx 2.
    acc_n = 0; hs_n = 0; hold = 0; held_once = 0; done_j = -1; busy_ready = 0;
    for (int j = 0; j < 40 && done_j < 0; j++) begin
      @(negedge clk);
      if (out_valid1 && out_idx1 == 2'd2 && !held_once) begin
        hold = 5;
        held_once = 1'b1;
      end
      out_ready = (hold == 0);
      if (hold > 0) hold--;
      in_valid = 1'b1;
      in_data  = mk(j);
      #1;
      if (in_ready1 && busy1) busy_ready++;
      if (in_ready1) acc_n++;
      if (out_valid1 && !out_ready) begin
        check($sformatf("hold_idx_j%0d", j), 136'(out_idx1), 136'd2);
        check($sformatf("hold_data_j%0d", j), out_data1, exp_out(mk(2)));
      end
      if (out_valid1 && out_ready) begin
        check($sformatf("p2_idx_%0d", hs_n), 136'(out_idx1), 136'(hs_n));
        check($sformatf("p2_data_%0d", hs_n), out_data1, exp_out(mk(hs_n)));
        check($sformatf("p2_fdone_%0d", hs_n), 136'(frame_done1), 136'(hs_n == 3));
        hs_n++;
        if (hs_n == 4) done_j = j;
      end
    end
    check("p2_done_cycle", 136'(done_j), 136'd22);
    check("p2_accepts", 136'(acc_n), 136'd4);
    check("p2_ready_while_busy", 136'(busy_ready), 136'd0);

    // Next frame starts the cycle after frame_done; reset lands in S2 cycle 2.
    for (int j = 23; j <= 33; j++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = mk(j);
      out_ready = 1'b1;
      #1;
      if (j == 23) check("p3_accept_after_done", 136'(in_ready1), 136'd1);
      if (j == 27) check("p3_ready_low_s1", 136'(in_ready1), 136'd0);
    end
    check("p3_rot_s2c2", 136'(bf_rot1), 136'b101);
    check("p3_bfin_s2c2", bf_in1, mk(24));
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset("mid");
    @(negedge clk);
    rst_n = 1'b1;

    run_frame("f2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
